// File: rtl/hazard_pkg.sv
// hazard_pkg: state encoding and default widths shared by the hazard/stall controller.
package hazard_pkg;
    localparam int REG_W_DEF = 5;
    localparam int CNT_W_DEF = 16;
    localparam logic [1:0] RUN         = 2'd0;
    localparam logic [1:0] LOAD_BUBBLE = 2'd1;
    localparam logic [1:0] MEM_FREEZE  = 2'd2;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
    parameter int CNT_W = hazard_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= '0;
        else if (clr) q <= '0;
        else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use bubbles, branch flushes and memory-wait freezes
// for the 5-stage pipeline, plus saturating stall/flush counters.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    logic [1:0] nxt;
    logic       bp, bp_nxt, is_run, load_use, flush, bubble;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= RUN;
            bp    <= 1'b0;
        end else begin
            state <= nxt;
            bp    <= bp_nxt;
        end

    // The illegal encoding 3 is decoded as RUN so it recovers on its own.
    always_comb begin
        is_run   = state != LOAD_BUBBLE && state != MEM_FREEZE;
        load_use = ex_mem_read && ex_rt != '0 &&
                   (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        flush    = !mem_busy && ((is_run && ex_branch_taken) ||
                   (state == MEM_FREEZE && (bp || ex_branch_taken)));
        bubble   = !mem_busy && is_run && !ex_branch_taken && load_use;
        nxt      = mem_busy ? MEM_FREEZE : bubble ? LOAD_BUBBLE : RUN;
        bp_nxt   = mem_busy && (bp || (ex_branch_taken && state != LOAD_BUBBLE));
    end

    always_comb begin
        pc_write   = reset && (mem_busy || bubble);
        ifid_hold  = reset && (mem_busy || bubble);
        ifid_flush = reset && flush;
        idex_hold  = reset && mem_busy;
        idex_flush = reset && (flush || bubble);
        exmem_hold = reset && mem_busy;
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk(clk), .reset(reset), .inc(pc_write), .clr(cnt_clr), .q(stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush (
        .clk(clk), .reset(reset), .inc(ifid_flush), .clr(cnt_clr), .q(flush_events)
    );
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed scenarios plus random traffic checked against
// a cycle-level behavioural model of the hazard rules (counters built with CNT_W=4).
module tb_hazard_stall_controller;
    localparam int CW = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0, reset = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic mem_busy = 1'b0, cnt_clr = 1'b0;
    logic pc_write, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold;
    logic [1:0] state;
    logic [CW-1:0] stall_cycles, flush_events;

    int checks = 0, passed = 0;
    int m_phase = 0;
    bit m_pend = 0;
    int m_stall = 0, m_flush = 0;

    hazard_stall_controller #(.REG_W(5), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .cnt_clr(cnt_clr), .pc_write(pc_write), .ifid_hold(ifid_hold),
        .ifid_flush(ifid_flush), .idex_hold(idex_hold), .idex_flush(idex_flush),
        .exmem_hold(exmem_hold), .state(state), .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [5:0] outs();
        return {pc_write, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold};
    endfunction

    // One pipeline cycle: apply inputs, compare at the falling edge, advance the model.
    // Model phases: 0 = normal flow, 1 = cycle after a load-use stall, 2 = inside a memory wait.
    task automatic step(input bit mb, input bit br, input bit mr, input bit uses,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                        input bit clr);
        bit lu, stall, fl;
        int nphase;
        logic [5:0] exp;
        mem_busy = mb; ex_branch_taken = br; ex_mem_read = mr; id_uses_rt = uses;
        id_rs = rs; id_rt = rt; ex_rt = ert; cnt_clr = clr;
        @(negedge clk);
        lu = mr && ert != 0 && (ert == rs || (uses && ert == rt));
        if (mb) begin
            exp = 6'b110101; nphase = 2; m_pend = m_pend || (br && m_phase != 1);
        end else if ((m_phase == 2 && (m_pend || br)) || (m_phase != 1 && m_phase != 2 && br)) begin
            exp = 6'b001010; nphase = 0; m_pend = 0;
        end else if (m_phase == 0 && lu) begin
            exp = 6'b110010; nphase = 1; m_pend = 0;
        end else begin
            exp = 6'b000000; nphase = 0; m_pend = 0;
        end
        check("outs", 32'(outs()), 32'(exp));
        check("state", 32'(state), 32'(m_phase));
        check("stall_cnt", 32'(stall_cycles), 32'(m_stall));
        check("flush_cnt", 32'(flush_events), 32'(m_flush));
        stall = exp[5];
        fl = exp[3];
        m_stall = clr ? 0 : (stall && m_stall < MAXC) ? m_stall + 1 : m_stall;
        m_flush = clr ? 0 : (fl && m_flush < MAXC) ? m_flush + 1 : m_flush;
        m_phase = nphase;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    initial begin
        mem_busy = 1'b1;
        ex_branch_taken = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", 32'(outs()), 0);
        check("rst_state", 32'(state), 0);
        reset = 1'b1;
        mem_busy = 1'b0;
        ex_branch_taken = 1'b0;

        // Load-use on rs, then one clean cycle.
        step(0, 0, 1, 0, 5'd8, 5'd0, 5'd8, 0);
        check("lu_stall", 32'(stall_cycles), 1);
        idle();
        // No false hazards.
        step(0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 1, 0, 5'd3, 5'd9, 5'd9, 0);
        step(0, 0, 1, 1, 5'd3, 5'd9, 5'd9, 0);
        idle();
        // Branch pulse.
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        check("br_flush", 32'(flush_events), 1);
        idle();
        // Freeze with branch arriving in its second cycle, flush on exit.
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();
        // Everything at once in RUN: freeze wins, no bubble afterwards.
        step(1, 1, 1, 0, 5'd4, 5'd0, 5'd4, 0);
        step(0, 0, 1, 0, 5'd4, 5'd0, 5'd4, 0);
        step(0, 0, 1, 0, 5'd4, 5'd0, 5'd4, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        // Saturation, then clear while stalling.
        repeat (20) step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        check("sat", 32'(stall_cycles), MAXC);
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
        check("clr", 32'(stall_cycles), 0);
        // Asynchronous reset in the middle of a freeze.
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        reset = 1'b0;
        #1;
        check("arst_outs", 32'(outs()), 0);
        check("arst_state", 32'(state), 0);
        check("arst_cnt", 32'(stall_cycles), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_phase = 0; m_pend = 0; m_stall = 0; m_flush = 0;
        // Random traffic over a small register range to hit matches often.
        for (int i = 0; i < 400; i++)
            step($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(1) == 0,
                 $urandom_range(1) == 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
                 5'($urandom_range(3)), $urandom_range(40) == 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline hazard and stall controller for the 5-stage MIPS core. It consumes decode/execute/memory status and produces the control that drives the fetch side of the pipeline: the PC hold/rewind request (`pc_write`), IF/ID hold and flush, ID/EX hold and flush, and EX/MEM hold. It sequences load-use bubbles, branch-taken flushes and data-memory wait freezes. It keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- REG_W, 5, register-address width
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- id_rs  in  REG_W  rs field of instruction in ID
- id_rt  in  REG_W  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  REG_W  load destination register in EX
- ex_branch_taken  in  1  branch/jump resolved taken in EX (may pulse)
- mem_busy  in  1  data memory not ready; pipeline must freeze
- cnt_clr  in  1  synchronous clear of both counters
- pc_write  out  1  1 = PC rewinds/holds current fetch address; 0 = PC loads next-PC
- ifid_hold  out  1  IF/ID keeps contents
- ifid_flush  out  1  IF/ID loaded with NOP
- idex_hold  out  1  ID/EX keeps contents
- idex_flush  out  1  ID/EX loaded with bubble
- exmem_hold  out  1  EX/MEM keeps contents
- state  out  2  current FSM state (debug)
- stall_cycles  out  CNT_W  cycles with pc_write=1, saturating
- flush_events  out  CNT_W  branch flushes applied, saturating

## Operation
- load_use = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- FSM states: RUN=0, LOAD_BUBBLE=1, MEM_FREEZE=2. Value 3 is illegal; it behaves as RUN and goes to RUN.
- Priority in every state: mem_busy > branch > load_use.
- RUN:
  - mem_busy=1: freeze outputs (pc_write, ifid_hold, idex_hold, exmem_hold = 1), then go to MEM_FREEZE. If ex_branch_taken=1 in the same cycle, set branch_pending.
  - else ex_branch_taken=1: ifid_flush=1, idex_flush=1, pc_write=0; flush_events increments; stay in RUN.
  - else load_use=1: pc_write=1, ifid_hold=1, idex_flush=1; go to LOAD_BUBBLE.
  - else: all outputs 0.
- LOAD_BUBBLE: lasts exactly one cycle. load_use and branch are ignored (EX holds a bubble). mem_busy=1 → freeze and go to MEM_FREEZE. Otherwise all outputs 0 and go to RUN.
- MEM_FREEZE:
  - mem_busy=1: freeze outputs; ex_branch_taken=1 sets branch_pending.
  - mem_busy=0: go to RUN.
    - If branch_pending or ex_branch_taken: apply the branch flush this cycle, increment flush_events, clear branch_pending.
    - Otherwise: outputs 0.
  - Load-use is never raised on the exit cycle.
- Counters: +1 per qualifying cycle, saturate at all-ones. cnt_clr has priority over increment.

## Timing
- Hazard outputs are combinational from (state, branch_pending, inputs), so they take effect in the same cycle. State, branch_pending and counters are registered on posedge clk.
- Load-use costs exactly 1 stall cycle. A branch costs 2 squashed instructions with 0 stall cycles. A freeze lasts exactly as many cycles as mem_busy is high.
- When reset is low: state=RUN, branch_pending=0, counters=0, and every hazard output is forced to 0 regardless of inputs. All of this applies immediately (asynchronous), including mid-freeze or mid-bubble.
- Never assert a hold and a flush on the same register in the same cycle.

## Structure
- Shared package `hazard_pkg`: state encoding constants (RUN, LOAD_BUBBLE, MEM_FREEZE) and the default REG_W/CNT_W.
- One natural sub-module: `sat_counter` (CNT_W, inc, clr, async active-low reset), instantiated twice.

## Test plan
- Load-use: lw $8 in EX, ID reads rs=8 → 1 cycle with pc_write=1, ifid_hold=1, idex_flush=1; next cycle all 0; stall_cycles=1.
- No false hazard: ex_rt=0 with id_rs=0, or id_uses_rt=0 with ex_rt==id_rt → outputs 0, state stays RUN.
- Branch: single-cycle pulse of ex_branch_taken → ifid_flush=idex_flush=1, pc_write=0 for that cycle; flush_events=1.
- Freeze with pending branch: mem_busy high 3 cycles, ex_branch_taken pulses in freeze cycle 2 → 3 freeze cycles, flush on exit cycle; stall_cycles=3, flush_events=1.
- Priority: mem_busy, branch and load_use all high in RUN → freeze only; state goes to MEM_FREEZE; no bubble afterwards.
- Reset/saturation: reset low mid-freeze → outputs 0 at once, state=RUN. With CNT_W=4, 20 stall cycles → stall_cycles=15; cnt_clr together with a stall → 0.
